// File: rtl/sequence_reveal.sv
// Timed LED presenter: dark gap, latched pattern for a show window, then dark plus a done pulse.
// Optional feature macro SEQ_REVEAL_BLINK_EN: blink the pattern during the show window.
module sequence_reveal #(
    parameter int WIDTH        = 8,
    parameter int GAP_CYCLES   = 5_000_000,
    parameter int SHOW_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 6_250_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2
    } state_e;

    localparam int MAX_CYCLES = (GAP_CYCLES > SHOW_CYCLES) ? GAP_CYCLES : SHOW_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);

    if (GAP_CYCLES < 1 || SHOW_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
        $error("sequence_reveal: cycle parameters must be >= 1");
    end

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   pat_q;
    logic [WIDTH-1:0]   led_q;
    logic               busy_q;
    logic               done_q;

`ifdef SEQ_REVEAL_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_on_q;
`endif

    // Reveal FSM; priority is reset, then abort, then start (which restarts from any state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_REVEAL_BLINK_EN
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
`endif
        end else if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start) begin
            state_q <= S_GAP;
            cnt_q   <= '0;
            pat_q   <= pattern;
            led_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    led_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                S_GAP: begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    if (cnt_q == GAP_LAST) begin
                        state_q <= S_SHOW;
                        cnt_q   <= '0;
                        led_q   <= pat_q;
`ifdef SEQ_REVEAL_BLINK_EN
                        blink_cnt_q <= '0;
                        blink_on_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        led_q <= '0;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        led_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
`ifdef SEQ_REVEAL_BLINK_EN
                        // Phase flips after BLINK_CYCLES cycles in the current phase.
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_q <= '0;
                            blink_on_q  <= ~blink_on_q;
                            led_q       <= blink_on_q ? '0 : pat_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                            led_q       <= blink_on_q ? pat_q : '0;
                        end
`else
                        led_q <= pat_q;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    led_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sequence_reveal.sv
// Scoreboard bench for sequence_reveal: a reveal-offset model queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sequence_reveal;

    localparam int G = 2;
    localparam int S = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [7:0] pattern, led;
    logic       busy, done;

    always #5 clk = ~clk;

    sequence_reveal #(
        .WIDTH(8), .GAP_CYCLES(G), .SHOW_CYCLES(S), .BLINK_CYCLES(B)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .led(led), .busy(busy), .done(done)
    );

    typedef struct {
        int         t;
        logic [7:0] led;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    bit         act    = 1'b0;
    int         s0     = 0;
    logic [7:0] pat_m  = 8'h00;

    // Expected outputs in the cycle after edge edge_n, from the offset since the last start.
    task automatic model(input bit r, input bit s, input bit a, input logic [7:0] p);
        exp_t e;
        int   k;
        if (r || a) act = 1'b0;
        else if (s) begin
            act   = 1'b1;
            s0    = edge_n;
            pat_m = p;
        end
        e.t = edge_n + 1; e.led = 8'h00; e.busy = 1'b0; e.done = 1'b0;
        if (act) begin
            k = e.t - s0;
            if (k >= 1 && k <= G + S) e.busy = 1'b1;
            if (k > G && k <= G + S) begin
`ifdef SEQ_REVEAL_BLINK_EN
                if (((k - G - 1) / B) % 2 == 0) e.led = pat_m;
`else
                e.led = pat_m;
`endif
            end
            if (k == G + S + 1) e.done = 1'b1;
            if (k > G + S + 1) act = 1'b0;
        end
        q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit s, input bit a, input logic [7:0] p);
        reset = r; start = s; abort = a; pattern = p;
        @(posedge clk);
        model(r, s, a, p);
        edge_n++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    // Monitor: every cycle carries an expectation, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks += 3;
            if (led !== e.led) begin
                errors++;
                $display("FAIL led cycle %0d got %h expected %h", e.t, led, e.led);
            end
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL busy cycle %0d got %b expected %b", e.t, busy, e.busy);
            end
            if (done !== e.done) begin
                errors++;
                $display("FAIL done cycle %0d got %b expected %b", e.t, done, e.done);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        idle(2);
        // plain reveal
        cyc(1'b0, 1'b1, 1'b0, 8'hA5); idle(12);
        // restart mid-reveal with a new pattern
        cyc(1'b0, 1'b1, 1'b0, 8'h3C); idle(3);
        cyc(1'b0, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 8'hFF); idle(12);
        // abort, then start+abort together from idle
        cyc(1'b0, 1'b1, 1'b0, 8'h81); idle(4);
        cyc(1'b0, 1'b0, 1'b1, 8'h81); idle(12);
        cyc(1'b0, 1'b1, 1'b1, 8'h42); idle(3);
        // reset in the fourth SHOW cycle, then a normal reveal
        cyc(1'b0, 1'b1, 1'b0, 8'h5A); idle(G + 3);
        cyc(1'b1, 1'b0, 1'b0, 8'h5A); idle(2);
        cyc(1'b0, 1'b1, 1'b0, 8'h0F); idle(12);
        // start in the done cycle
        cyc(1'b0, 1'b1, 1'b0, 8'hC3); idle(G + S);
        cyc(1'b0, 1'b1, 1'b0, 8'h96); idle(12);
        // start in the last SHOW cycle suppresses done
        cyc(1'b0, 1'b1, 1'b0, 8'h77); idle(G + S - 1);
        cyc(1'b0, 1'b1, 1'b0, 8'h18); idle(12);
        // randomized traffic
        for (int i = 0; i < 500; i++)
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 39) == 0), 8'($urandom));
        idle(14);
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
